// File: rtl/a1000_daug_pkg.sv
// Shared types and address constants for the A1000 daughterboard bus controller.
// Region decode lives here so the top module and any future sub-block agree on it.
package a1000_daug_pkg;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_BOOT,
        REG_WCS
    } region_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        ACK,
        HOLD
    } state_e;

    localparam logic [5:0] BOOT_BASE = 6'h3E;
    localparam logic [5:0] WCS_BASE  = 6'h3F;
    localparam logic [4:0] OVL_LIMIT = 5'h00;

    // a_hi is A[23:18]; the overlay window is the low 512 KB, i.e. A[23:19] == 0.
    function automatic region_e decode_region(input logic [5:0] a_hi,
                                              input logic       ovl,
                                              input logic       prw);
        if (a_hi == BOOT_BASE) begin
            return REG_BOOT;
        end
        if (a_hi == WCS_BASE) begin
            return REG_WCS;
        end
        if (ovl && prw && (a_hi[5:1] == OVL_LIMIT)) begin
            return REG_BOOT;
        end
        return REG_NONE;
    endfunction

endpackage

// File: rtl/a1000_daug_bus_ctrl_sync.sv
// N-stage synchronizer for one asynchronous 68000 strobe into the CLK domain.
// Resets to the strobe's inactive level so a reset never looks like a new bus cycle.
module a1000_sync_n #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/a1000_daug_bus_ctrl.sv
// Bus-cycle sequencer for the A1000 daughterboard: boot ROM, WCS and overlay decode,
// chip strobes with wait states / XRDY stretching, _DTACK enable and the WCS write lock.
module a1000_daug_bus_ctrl
    import a1000_daug_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned XRDY_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:1] A,
    input  logic        _AS,
    input  logic        _UDS,
    input  logic        _LDS,
    input  logic        _PRW,
    input  logic        OVL,
    input  logic        XRDY,
    output logic        DTACK_OE,
    output logic        _ROME,
    output logic        _WCSOE,
    output logic        _WCSWE_U,
    output logic        _WCSWE_L,
    output logic        LOCKED,
    output logic        TIMEOUT,
    output state_e      dbg_state
);

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [7:0] XRDY_LIM = 8'(XRDY_TIMEOUT);

    logic as_s;
    logic uds_s;
    logic lds_s;

    a1000_sync_n #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_as (
        .clk (CLK),
        .rst (RST),
        .d   (_AS),
        .q   (as_s)
    );

    a1000_sync_n #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_uds (
        .clk (CLK),
        .rst (RST),
        .d   (_UDS),
        .q   (uds_s)
    );

    a1000_sync_n #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lds (
        .clk (CLK),
        .rst (RST),
        .d   (_LDS),
        .q   (lds_s)
    );

    // Only A[23:18] takes part in the decode; the low bits belong to the devices.
    logic unused_addr;
    assign unused_addr = ^A[17:1];

    region_e dec_region;
    always_comb begin
        dec_region = decode_region(A[23:18], OVL, _PRW);
    end

    state_e     state_q,    state_d;
    region_e    region_q,   region_d;
    logic       prw_q,      prw_d;
    logic [1:0] lane_q,     lane_d;
    logic [3:0] wcnt_q,     wcnt_d;
    logic [7:0] xcnt_q,     xcnt_d;
    logic       dtack_q,    dtack_d;
    logic       rome_n_q,   rome_n_d;
    logic       wcsoe_n_q,  wcsoe_n_d;
    logic       weu_n_q,    weu_n_d;
    logic       wel_n_q,    wel_n_d;
    logic       locked_q,   locked_d;
    logic       timeout_q,  timeout_d;

    logic [3:0] wcnt_inc;
    logic [7:0] xcnt_inc;
    logic       go_idle;
    logic       go_ack;

    always_comb begin
        wcnt_inc = (wcnt_q == 4'hF) ? 4'hF : wcnt_q + 4'd1;
        xcnt_inc = (xcnt_q == 8'hFF) ? 8'hFF : xcnt_q + 8'd1;
    end

    // Handshake: the 68000 holds _AS low for the whole cycle; we answer by enabling _DTACK
    // in ACK and keep it (and any chip strobe) until the synced _AS is seen high again.
    always_comb begin
        state_d   = state_q;
        region_d  = region_q;
        prw_d     = prw_q;
        lane_d    = lane_q;
        wcnt_d    = wcnt_q;
        xcnt_d    = xcnt_q;
        dtack_d   = dtack_q;
        rome_n_d  = rome_n_q;
        wcsoe_n_d = wcsoe_n_q;
        weu_n_d   = weu_n_q;
        wel_n_d   = wel_n_q;
        locked_d  = locked_q;
        timeout_d = 1'b0;
        go_idle   = 1'b0;
        go_ack    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!as_s) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (as_s) begin
                    go_idle = 1'b1;
                end else begin
                    region_d = dec_region;
                    prw_d    = _PRW;
                    lane_d   = {~uds_s, ~lds_s};
                    if (dec_region == REG_NONE) begin
                        state_d = HOLD;
                    end else begin
                        state_d   = WAIT;
                        wcnt_d    = 4'd0;
                        xcnt_d    = 8'd0;
                        rome_n_d  = !(_PRW && dec_region == REG_BOOT);
                        wcsoe_n_d = !(_PRW && dec_region == REG_WCS);
                        weu_n_d   = !(!_PRW && dec_region == REG_WCS && !locked_q && lane_d[1]);
                        wel_n_d   = !(!_PRW && dec_region == REG_WCS && !locked_q && lane_d[0]);
                    end
                end
            end
            WAIT: begin
                if (as_s) begin
                    go_idle = 1'b1;
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc >= WAIT_LIM) begin
                        if (XRDY) begin
                            go_ack = 1'b1;
                        end else begin
                            xcnt_d = xcnt_inc;
                            if (xcnt_inc >= XRDY_LIM) begin
                                go_ack    = 1'b1;
                                timeout_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ACK: begin
                if (as_s) begin
                    go_idle = 1'b1;
                end
            end
            HOLD: begin
                if (as_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_ack) begin
            state_d = ACK;
            dtack_d = 1'b1;
            // A write into the boot-ROM window freezes the kickstart image in the WCS.
            if (!prw_q && region_q == REG_BOOT) begin
                locked_d = 1'b1;
            end
        end

        if (go_idle) begin
            state_d   = IDLE;
            dtack_d   = 1'b0;
            rome_n_d  = 1'b1;
            wcsoe_n_d = 1'b1;
            weu_n_d   = 1'b1;
            wel_n_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            region_q  <= REG_NONE;
            prw_q     <= 1'b1;
            lane_q    <= 2'b00;
            wcnt_q    <= 4'd0;
            xcnt_q    <= 8'd0;
            dtack_q   <= 1'b0;
            rome_n_q  <= 1'b1;
            wcsoe_n_q <= 1'b1;
            weu_n_q   <= 1'b1;
            wel_n_q   <= 1'b1;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            region_q  <= region_d;
            prw_q     <= prw_d;
            lane_q    <= lane_d;
            wcnt_q    <= wcnt_d;
            xcnt_q    <= xcnt_d;
            dtack_q   <= dtack_d;
            rome_n_q  <= rome_n_d;
            wcsoe_n_q <= wcsoe_n_d;
            weu_n_q   <= weu_n_d;
            wel_n_q   <= wel_n_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign DTACK_OE  = dtack_q;
    assign _ROME     = rome_n_q;
    assign _WCSOE    = wcsoe_n_q;
    assign _WCSWE_U  = weu_n_q;
    assign _WCSWE_L  = wel_n_q;
    assign LOCKED    = locked_q;
    assign TIMEOUT   = timeout_q;
    assign dbg_state = state_q;

endmodule
